// File: rtl/dri_stage_sequencer.sv
// Two-stage DRI reconstruction sequencer: drives the core through a 4x4 preview
// and an 8x8 refinement, checks per-stage pixel counts and stage-tags the pixel writes.
module dri_stage_sequencer #(
    parameter int S0_N           = 15,
    parameter int S0_M           = 1,
    parameter int S0_K           = 4,
    parameter int S1_N           = 63,
    parameter int S1_M           = 7,
    parameter int S1_K           = 16,
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [5:0]  cfg_N,
    output logic [2:0]  cfg_M,
    output logic [4:0]  cfg_K,
    output logic        sys_start,
    input  logic        sys_done,
    input  logic        pix_we_in,
    input  logic [5:0]  pix_addr_in,
    input  logic [23:0] pix_val_in,
    output logic        fb_we,
    output logic [6:0]  fb_addr,
    output logic [23:0] fb_val,
    output logic        stage,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {IDLE, LOAD, PULSE, WAIT_DONE, GAP, DONE, ERR} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t          state_q;
    logic            stage_q;
    logic [5:0]      cfg_n_q;
    logic [2:0]      cfg_m_q;
    logic [4:0]      cfg_k_q;
    logic            sys_start_q;
    logic            sys_done_q;
    logic [6:0]      pix_cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [GW-1:0]   gap_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic [1:0]      err_code_q;
    logic            fb_we_q;
    logic [6:0]      fb_addr_q;
    logic [23:0]     fb_val_q;

    logic            done_edge;
    logic [7:0]      wr_total;
    logic [7:0]      wr_expect;
    logic [TW-1:0]   tmo_nxt;

    // A write landing in the same cycle as the done edge still counts.
    assign done_edge = sys_done & ~sys_done_q;
    assign wr_total  = {1'b0, pix_cnt_q} + {7'd0, pix_we_in};
    assign wr_expect = {2'b00, cfg_n_q} + 8'd1;
    assign tmo_nxt   = tmo_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_q     <= 1'b0;
            cfg_n_q     <= 6'(S0_N);
            cfg_m_q     <= 3'(S0_M);
            cfg_k_q     <= 5'(S0_K);
            sys_start_q <= 1'b0;
            sys_done_q  <= 1'b0;
            pix_cnt_q   <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            sys_start_q <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                stage_q    <= 1'b0;
                cfg_n_q    <= 6'(S0_N);
                cfg_m_q    <= 3'(S0_M);
                cfg_k_q    <= 5'(S0_K);
                pix_cnt_q  <= '0;
                tmo_q      <= '0;
                gap_q      <= '0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                err_code_q <= 2'd0;
            end else begin
                unique case (state_q)
                    IDLE, DONE, ERR: begin
                        if (start) begin
                            state_q    <= LOAD;
                            stage_q    <= 1'b0;
                            cfg_n_q    <= 6'(S0_N);
                            cfg_m_q    <= 3'(S0_M);
                            cfg_k_q    <= 5'(S0_K);
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            err_code_q <= 2'd0;
                        end
                    end
                    LOAD: begin
                        if (pix_we_in) begin
                            state_q    <= ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd3;
                        end else begin
                            state_q     <= PULSE;
                            sys_start_q <= 1'b1;
                        end
                    end
                    PULSE: begin
                        // Capture the current done level so a stale high is not an edge.
                        sys_done_q <= sys_done;
                        pix_cnt_q  <= '0;
                        tmo_q      <= '0;
                        if (pix_we_in) begin
                            state_q    <= ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd3;
                        end else begin
                            state_q <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        sys_done_q <= sys_done;
                        tmo_q      <= tmo_nxt;
                        if (pix_we_in && pix_cnt_q != 7'd127)
                            pix_cnt_q <= pix_cnt_q + 7'd1;
                        if (done_edge) begin
                            if (wr_total != wr_expect) begin
                                state_q    <= ERR;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                                err_code_q <= 2'd2;
                            end else if (!stage_q) begin
                                state_q <= GAP;
                                gap_q   <= '0;
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else if (tmo_nxt == TW'(TIMEOUT_CYCLES - 1)) begin
                            state_q    <= ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd1;
                        end
                    end
                    GAP: begin
                        if (pix_we_in) begin
                            state_q    <= ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd3;
                        end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
                            state_q <= LOAD;
                            stage_q <= 1'b1;
                            cfg_n_q <= 6'(S1_N);
                            cfg_m_q <= 3'(S1_M);
                            cfg_k_q <= 5'(S1_K);
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Pixel path: one register stage, writes accepted only while waiting on the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_val_q  <= '0;
        end else begin
            fb_we_q   <= pix_we_in && (state_q == WAIT_DONE);
            fb_addr_q <= {stage_q, pix_addr_in};
            fb_val_q  <= pix_val_in;
        end
    end

    assign cfg_N     = cfg_n_q;
    assign cfg_M     = cfg_m_q;
    assign cfg_K     = cfg_k_q;
    assign sys_start = sys_start_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_val    = fb_val_q;
    assign stage     = stage_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_dri_stage_sequencer.sv
// Directed-sequence bench for dri_stage_sequencer with randomized pixel traffic
// checked against a stage-table reference model.
module tb_dri_stage_sequencer;

    localparam int GAP = 50;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst, start, abort, sys_done, pix_we_in;
    logic [5:0]  pix_addr_in;
    logic [23:0] pix_val_in;
    logic [5:0]  cfg_N;
    logic [2:0]  cfg_M;
    logic [4:0]  cfg_K;
    logic        sys_start, fb_we, stage, busy, done, error;
    logic [6:0]  fb_addr;
    logic [23:0] fb_val;
    logic [1:0]  err_code;

    dri_stage_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_N(cfg_N), .cfg_M(cfg_M), .cfg_K(cfg_K), .sys_start(sys_start),
        .sys_done(sys_done), .pix_we_in(pix_we_in), .pix_addr_in(pix_addr_in),
        .pix_val_in(pix_val_in), .fb_we(fb_we), .fb_addr(fb_addr), .fb_val(fb_val),
        .stage(stage), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int pulses = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sys_start) pulses <= pulses + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: per-stage configuration table and run outcome rules.
    int MN[2] = '{15, 63};
    int MM[2] = '{1, 7};
    int MK[2] = '{4, 16};

    function automatic int model_code(int w0, int w1);
        if (w0 != MN[0] + 1) return 2;
        if (w1 != MN[1] + 1) return 2;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_cfgN"}, 32'(cfg_N), MN[0]);
        chk({tag, "_cfgM"}, 32'(cfg_M), MM[0]);
        chk({tag, "_cfgK"}, 32'(cfg_K), MK[0]);
        chk({tag, "_ctl"}, 32'({sys_start, fb_we, stage, busy, done, error, err_code}), 0);
        chk({tag, "_fb"}, 32'({fb_addr, fb_val}), 0);
    endtask

    task automatic wait_pulse(input int s, output int t);
        bit seen;
        seen = 1'b0;
        t = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (sys_start === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        chk("pulse_seen", 32'(seen), 1);
        if (seen) begin
            chk("pulse_cfgN", 32'(cfg_N), MN[s]);
            chk("pulse_cfgM", 32'(cfg_M), MM[s]);
            chk("pulse_cfgK", 32'(cfg_K), MK[s]);
            chk("pulse_stage", 32'(stage), s);
            chk("pulse_flags", 32'({busy, done, error, err_code}), 32'b10000);
        end
        @(negedge clk);
        chk("pulse_width", 32'(sys_start), 0);
    endtask

    task automatic pulse_done(output int t);
        @(negedge clk);
        sys_done = 1'b1;
        t = cyc;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sys_done = 1'b0;
    endtask

    // mode 0: writes only; 1: writes then done edge; 2: done edge with the last write
    task automatic run_stage(input int s, input int nw, input int mode, output int t);
        logic [23:0] v;
        int budget;
        budget = 20;
        t = 0;
        for (int i = 0; i < nw; i++) begin
            if (budget > 0 && $urandom_range(0, 3) == 0) begin
                budget--;
                @(negedge clk);
            end
            v = 24'($urandom);
            pix_we_in = 1'b1;
            pix_addr_in = 6'(i);
            pix_val_in = v;
            if (mode == 2 && i == nw - 1) begin
                sys_done = 1'b1;
                t = cyc;
            end
            @(negedge clk);
            pix_we_in = 1'b0;
            chk("fb_we", 32'(fb_we), 1);
            chk("fb_addr", 32'(fb_addr), s * 64 + i);
            chk("fb_val", 32'(fb_val), 32'(v));
        end
        if (mode == 1) pulse_done(t);
        if (mode == 2) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sys_done = 1'b0;
        end
    endtask

    task automatic wait_end(output int t);
        bit seen;
        seen = 1'b0;
        t = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        chk("end_seen", 32'(seen), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tp, p0;
        logic [23:0] v;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sys_done = 1'b0;
        pix_we_in = 1'b0; pix_addr_in = '0; pix_val_in = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("idle");

        // Nominal two-stage run, last stage-0 write coincident with the done edge
        p0 = pulses;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        run_stage(0, 16, 2, t0);
        wait_pulse(1, tp);
        chk("gap_timing", tp - t0, GAP + 2);
        run_stage(1, 64, 1, t0);
        wait_end(t1);
        chk("nom_done", 32'({done, error, busy}), 32'b100);
        chk("nom_code", 32'(err_code), model_code(16, 64));
        chk("nom_pulses", pulses - p0, 2);

        // Stale done level must not count as completion
        p0 = pulses;
        sys_done = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        run_stage(0, 16, 0, t0);
        repeat (3) @(negedge clk);
        chk("stale_busy", 32'({busy, error, stage}), 32'b100);
        sys_done = 1'b0;
        pulse_done(t0);
        wait_pulse(1, tp);
        chk("stale_gap", tp - t0, GAP + 2);
        run_stage(1, 64, 2, t0);
        wait_end(t1);
        chk("stale_done", 32'({done, error}), 32'b10);
        chk("stale_pulses", pulses - p0, 2);

        // Count mismatch in stage 0; start while busy is ignored
        p0 = pulses;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        start = 1'b1; @(negedge clk); start = 1'b0;
        run_stage(0, 15, 1, t0);
        wait_end(t1);
        chk("mm_error", 32'({done, error, busy}), 32'b010);
        chk("mm_code", 32'(err_code), model_code(15, 0));
        chk("mm_stage", 32'(stage), 0);
        repeat (GAP + 10) @(negedge clk);
        chk("mm_pulses", pulses - p0, 1);

        // Timeout: done never rises
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, t0);
        wait_end(t1);
        chk("tmo_cycles", t1 - t0, TMO);
        chk("tmo_code", 32'({error, err_code}), 32'b101);

        // Abort mid stage 1 together with start and a write
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        run_stage(0, 16, 1, t0);
        wait_pulse(1, tp);
        run_stage(1, 10, 0, t0);
        v = 24'($urandom);
        abort = 1'b1; start = 1'b1; pix_we_in = 1'b1; pix_addr_in = 6'd33; pix_val_in = v;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; pix_we_in = 1'b0;
        chk("abort_fb", 32'({fb_we, fb_addr}), 32'({1'b1, 7'd97}));
        chk("abort_val", 32'(fb_val), 32'(v));
        chk("abort_ctl", 32'({sys_start, stage, busy, done, error, err_code}), 0);
        chk("abort_cfgN", 32'(cfg_N), MN[0]);
        @(negedge clk);
        chk("abort_idle", 32'({fb_we, busy}), 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        run_stage(0, 16, 1, t0);
        wait_pulse(1, tp);
        run_stage(1, 64, 2, t0);
        wait_end(t1);
        chk("restart_done", 32'({done, error}), 32'b10);

        // Asynchronous reset in stage-1 WAIT_DONE
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        run_stage(0, 16, 1, t0);
        wait_pulse(1, tp);
        run_stage(1, 3, 0, t0);
        #1 rst = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stray write during GAP
        p0 = pulses;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pulse(0, tp);
        run_stage(0, 16, 1, t0);
        repeat (5) @(negedge clk);
        pix_we_in = 1'b1; pix_addr_in = 6'($urandom); pix_val_in = 24'($urandom);
        @(negedge clk);
        pix_we_in = 1'b0;
        chk("stray_fbwe", 32'(fb_we), 0);
        chk("stray_err", 32'({error, err_code, busy}), 32'b1110);
        repeat (GAP + 5) @(negedge clk);
        chk("stray_pulses", pulses - p0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
